// File: rtl/axi_pkg.sv
// Shared definitions for the AXI read sequencer: FSM encoding, beat-count type
// and the default beat size.
package axi_pkg;

    localparam int unsigned BEAT_BYTES_DEFAULT = 4;
    localparam int unsigned BEAT_CNT_W         = 9;

    typedef logic [BEAT_CNT_W-1:0] beat_cnt_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } seq_state_t;

    // cmd_len encodes beats minus one; 255 needs the ninth bit once incremented.
    function automatic beat_cnt_t beats_from_len(input logic [7:0] len);
        return beat_cnt_t'(len) + beat_cnt_t'(1);
    endfunction

endpackage

// File: rtl/axi_rd_fifo.sv
// First-word-fall-through buffer holding read beats with their last tags.
// The head is visible combinationally so a beat can leave every cycle.
module axi_rd_fifo #(
    parameter  int unsigned DEPTH  = 4,
    parameter  int unsigned DATA_W = 32,
    localparam int unsigned PTR_W  = $clog2(DEPTH),
    localparam int unsigned CNT_W  = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              push_last,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              head_last,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W:0]  mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             pop_ok;

    assign empty  = (count_reg == '0);
    assign pop_ok = pop && !empty;
    assign count  = count_reg;

    // Outputs are forced to zero while empty so reset clears them immediately.
    assign head_data = empty ? '0 : mem[rd_ptr_reg][DATA_W-1:0];
    assign head_last = empty ? 1'b0 : mem[rd_ptr_reg][DATA_W];

    always_comb begin
        count_next = count_reg;
        case ({push, pop_ok})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {push_last, push_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/axi_rd_seq.sv
// Turns a burst command into a stream of single-cycle SRAM reads and presents
// the returned words as AXI read beats through a small credit-limited buffer.
module axi_rd_seq
    import axi_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned BEAT_BYTES = BEAT_BYTES_DEFAULT
) (
    input  logic        ACLK,
    input  logic        ARESETn,
    input  logic        cmd_valid,
    input  logic [31:0] cmd_addr,
    input  logic [7:0]  cmd_len,
    output logic        cmd_ready,
    output logic        mem_en,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    output logic        r_valid,
    output logic        r_last,
    output logic [31:0] data_out,
    input  logic        r_ready,
    output logic        busy
);

    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned USED_W = CNT_W + 1;

    seq_state_t  state_reg, state_next;
    logic [31:0] addr_reg, addr_next;
    beat_cnt_t   remaining_reg, remaining_next;
    logic        inflight_reg;
    logic        inflight_last_reg;
    logic        started_reg;

    logic             issue_en;
    logic             issue_last;
    logic             credit_ok;
    logic             pop;
    logic             fifo_empty;
    logic             head_last;
    logic [CNT_W-1:0] fifo_count;
    logic [USED_W-1:0] used;

    // Every buffer slot is either occupied or promised to a read in flight.
    assign used      = USED_W'(fifo_count) + USED_W'(inflight_reg);
    assign credit_ok = (used < USED_W'(FIFO_DEPTH));
    assign pop       = !fifo_empty && r_ready;

    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        remaining_next = remaining_reg;
        issue_en       = 1'b0;
        issue_last     = 1'b0;
        cmd_ready      = (state_reg == ST_IDLE) && started_reg;
        case (state_reg)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    addr_next      = cmd_addr;
                    remaining_next = beats_from_len(cmd_len);
                    state_next     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (credit_ok) begin
                    issue_en       = 1'b1;
                    addr_next      = addr_reg + 32'(BEAT_BYTES);
                    remaining_next = remaining_reg - beat_cnt_t'(1);
                    if (remaining_reg == beat_cnt_t'(1)) begin
                        issue_last = 1'b1;
                        state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (pop && head_last) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // started_reg holds cmd_ready low until the first edge after reset release.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_reg         <= ST_IDLE;
            addr_reg          <= '0;
            remaining_reg     <= '0;
            inflight_reg      <= 1'b0;
            inflight_last_reg <= 1'b0;
            started_reg       <= 1'b0;
        end else begin
            state_reg         <= state_next;
            addr_reg          <= addr_next;
            remaining_reg     <= remaining_next;
            inflight_reg      <= issue_en;
            inflight_last_reg <= issue_last;
            started_reg       <= 1'b1;
        end
    end

    axi_rd_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (32)
    ) u_fifo (
        .clk       (ACLK),
        .rst_n     (ARESETn),
        .push      (inflight_reg),
        .push_data (mem_rdata),
        .push_last (inflight_last_reg),
        .pop       (pop),
        .head_data (data_out),
        .head_last (head_last),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign mem_en   = issue_en;
    assign mem_addr = addr_reg;
    assign r_valid  = !fifo_empty;
    assign r_last   = head_last;
    assign busy     = (state_reg != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_axi_rd_seq.sv
// Bench for axi_rd_seq: SRAM model plus per-burst expected address and beat queues.
module tb_axi_rd_seq;

    localparam int DEPTH = 4;
    localparam int BB    = 4;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [7:0]  cmd_len = '0;
    logic        cmd_ready;
    logic        mem_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata = '0;
    logic        r_valid;
    logic        r_last;
    logic [31:0] data_out;
    logic        r_ready = 1'b0;
    logic        busy;

    int checks = 0;
    int errors = 0;

    axi_rd_seq #(.FIFO_DEPTH(DEPTH), .BEAT_BYTES(BB)) dut (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .cmd_valid (cmd_valid),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .cmd_ready (cmd_ready),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .r_valid   (r_valid),
        .r_last    (r_last),
        .data_out  (data_out),
        .r_ready   (r_ready),
        .busy      (busy)
    );

    always #5 ACLK = ~ACLK;

    function automatic logic [31:0] sram_word(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'hC0DE_1234;
    endfunction

    // SRAM: data valid one cycle after the strobe, garbage otherwise.
    always @(posedge ACLK) begin
        if (mem_en) mem_rdata <= sram_word(mem_addr);
        else        mem_rdata <= $urandom();
    end

    // rr_mode: 0 = r_ready always high, 1 = random, 2 = low for `hold` cycles then high.
    task automatic test_burst(input logic [31:0] addr, input int len, input int rr_mode,
                              input int hold, input string name,
                              output int first_en, output int first_rv, output int en_hold);
        logic [31:0] exp_addr[$];
        logic [32:0] exp_beat[$];
        logic [32:0] prev;
        logic        have_prev;
        int t, issued, popped, last_pop_t, budget, waited;
        for (int i = 0; i <= len; i++) begin
            logic [31:0] a;
            a = addr + 32'(i * BB);
            exp_addr.push_back(a);
            exp_beat.push_back({(i == len), sram_word(a)});
        end
        first_en = -1; first_rv = -1; en_hold = 0;
        t = 0; issued = 0; popped = 0; last_pop_t = -1; have_prev = 1'b0; prev = '0;
        budget = (len + 1) * 8 + hold + 40;

        waited = 0;
        @(negedge ACLK);
        while (!cmd_ready && waited < 20) begin
            @(negedge ACLK);
            waited++;
        end
        checks++;
        if (!cmd_ready) begin
            errors++;
            $display("FAIL %s cmd_ready_wait got 0 want 1", name);
            return;
        end
        cmd_valid = 1'b1; cmd_addr = addr; cmd_len = 8'(len);
        r_ready = (rr_mode == 0);

        while (popped < len + 1 && t < budget) begin
            @(negedge ACLK);
            t++;
            cmd_valid = 1'b0;
            if (rr_mode == 0)      r_ready = 1'b1;
            else if (rr_mode == 1) r_ready = 1'($urandom_range(0, 1));
            else                   r_ready = (t > hold);

            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL %s busy t=%0d got %b want 1", name, t, busy);
            end
            if (mem_en) begin
                if (first_en < 0) first_en = t;
                if (t <= hold) en_hold++;
                checks++;
                if (exp_addr.size() == 0) begin
                    errors++;
                    $display("FAIL %s extra_mem_en t=%0d addr %h want none", name, t, mem_addr);
                end else begin
                    if (mem_addr !== exp_addr[0]) begin
                        errors++;
                        $display("FAIL %s mem_addr t=%0d got %h want %h", name, t, mem_addr, exp_addr[0]);
                    end
                    void'(exp_addr.pop_front());
                end
                issued++;
            end
            if (have_prev) begin
                checks++;
                if (r_valid !== 1'b1 || {r_last, data_out} !== prev) begin
                    errors++;
                    $display("FAIL %s stall_hold t=%0d got v=%b %h want v=1 %h",
                             name, t, r_valid, {r_last, data_out}, prev);
                end
            end
            if (r_valid && first_rv < 0) first_rv = t;
            if (r_valid && r_ready) begin
                checks++;
                if (exp_beat.size() == 0) begin
                    errors++;
                    $display("FAIL %s extra_beat t=%0d got %h want none", name, t, data_out);
                end else begin
                    if ({r_last, data_out} !== exp_beat[0]) begin
                        errors++;
                        $display("FAIL %s beat%0d got last=%b %h want last=%b %h", name, popped,
                                 r_last, data_out, exp_beat[0][32], exp_beat[0][31:0]);
                    end
                    void'(exp_beat.pop_front());
                end
                if (rr_mode == 0 && last_pop_t >= 0) begin
                    checks++;
                    if (t != last_pop_t + 1) begin
                        errors++;
                        $display("FAIL %s gap beat%0d at t=%0d want t=%0d", name, popped, t, last_pop_t + 1);
                    end
                end
                last_pop_t = t;
                popped++;
            end
            checks++;
            if (issued - popped > DEPTH) begin
                errors++;
                $display("FAIL %s outstanding t=%0d got %0d want <=%0d", name, t, issued - popped, DEPTH);
            end
            have_prev = r_valid && !r_ready;
            prev = {r_last, data_out};
        end

        checks++;
        if (popped != len + 1) begin
            errors++;
            $display("FAIL %s beat_count got %0d want %0d", name, popped, len + 1);
        end
        @(negedge ACLK);
        r_ready = 1'b0;
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || r_valid !== 1'b0 || mem_en !== 1'b0
            || exp_addr.size() != 0) begin
            errors++;
            $display("FAIL %s idle_after got rdy=%b busy=%b rv=%b en=%b left=%0d want 1 0 0 0 0",
                     name, cmd_ready, busy, r_valid, mem_en, exp_addr.size());
        end
        $display("burst %s addr=%h len=%0d mode=%0d beats=%0d", name, addr, len, rr_mode, popped);
    endtask

    task automatic test_reset();
        ARESETn = 1'b0;
        #2;
        checks++;
        if ({cmd_ready, mem_en, mem_addr, r_valid, r_last, data_out, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b en=%b a=%h rv=%b rl=%b d=%h busy=%b want all 0",
                     cmd_ready, mem_en, mem_addr, r_valid, r_last, data_out, busy);
        end
        @(negedge ACLK);
        ARESETn = 1'b1;
        @(negedge ACLK);
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || r_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got rdy=%b busy=%b rv=%b want 1 0 0", cmd_ready, busy, r_valid);
        end
        $display("reset checked");
    endtask

    task automatic test_basic();
        int fe, fr, eh;
        test_burst(32'h0000_0100, 3, 0, 0, "basic", fe, fr, eh);
        checks++;
        if (fe != 1 || fr != 3) begin
            errors++;
            $display("FAIL latency got mem_en@%0d r_valid@%0d want 1 3", fe, fr);
        end
    endtask

    task automatic test_len0();
        int fe, fr, eh;
        test_burst({$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, 0, 0, 0, "len0", fe, fr, eh);
    endtask

    task automatic test_backpressure();
        int fe, fr, eh;
        test_burst(32'h0000_2000, 15, 2, 20, "backpressure", fe, fr, eh);
        checks++;
        if (eh != 4) begin
            errors++;
            $display("FAIL hold_mem_en got %0d want 4", eh);
        end
    endtask

    task automatic test_wrap();
        int fe, fr, eh;
        test_burst(32'hFFFF_FFF8, 3, 0, 0, "wrap", fe, fr, eh);
    endtask

    task automatic test_random();
        int fe, fr, eh;
        test_burst({$urandom(), 2'b00} & 32'hFFFF_FFFC, 255, 1, 0, "random255", fe, fr, eh);
        for (int n = 0; n < 6; n++) begin
            test_burst({$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, int'($urandom_range(0, 40)),
                       int'($urandom_range(0, 1)), 0, "back_to_back", fe, fr, eh);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [31:0] base;
        int popped, t, fe, fr, eh;
        base = 32'h0000_4000;
        popped = 0; t = 0;
        @(negedge ACLK);
        cmd_valid = 1'b1; cmd_addr = base; cmd_len = 8'd7;
        r_ready = 1'b1;
        while (t < 60) begin
            @(negedge ACLK);
            t++;
            cmd_valid = 1'b0;
            if (r_valid && popped == 4) break;
            if (r_valid) begin
                checks++;
                if (data_out !== sram_word(base + 32'(popped * BB))) begin
                    errors++;
                    $display("FAIL rst_mid beat%0d got %h want %h", popped, data_out,
                             sram_word(base + 32'(popped * BB)));
                end
                popped++;
            end
        end
        checks++;
        if (popped != 4) begin
            errors++;
            $display("FAIL rst_mid reach_beat5 got %0d beats want 4", popped);
        end
        ARESETn = 1'b0;
        #1;
        checks++;
        if ({cmd_ready, mem_en, mem_addr, r_valid, r_last, data_out, busy} !== '0) begin
            errors++;
            $display("FAIL rst_mid outputs got rdy=%b en=%b a=%h rv=%b rl=%b d=%h busy=%b want all 0",
                     cmd_ready, mem_en, mem_addr, r_valid, r_last, data_out, busy);
        end
        r_ready = 1'b0;
        @(negedge ACLK);
        @(negedge ACLK);
        ARESETn = 1'b1;
        @(negedge ACLK);
        checks++;
        if (cmd_ready !== 1'b1 || r_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid release got rdy=%b rv=%b busy=%b want 1 0 0", cmd_ready, r_valid, busy);
        end
        $display("reset mid-burst after %0d beats", popped);
        test_burst(32'h0000_8000, 5, 1, 0, "after_reset", fe, fr, eh);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len0();
        test_backpressure();
        test_wrap();
        test_random();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
